// File: rtl/bram_port_arbiter_if.sv
// Bundle shared by the port-A arbiter: two requester handshakes,
// the returned read data, and the RAM port A wires.
interface bram_port_arbiter_if #(
    parameter int DATA = 8,
    parameter int ADDR = 10
);
    logic            m0_req;
    logic            m0_we;
    logic [ADDR-1:0] m0_addr;
    logic [DATA-1:0] m0_wdata;
    logic            m0_ack;
    logic            m0_rvalid;

    logic            m1_req;
    logic            m1_we;
    logic [ADDR-1:0] m1_addr;
    logic [DATA-1:0] m1_wdata;
    logic            m1_ack;
    logic            m1_rvalid;

    logic [DATA-1:0] rdata;

    logic            ram_we;
    logic [ADDR-1:0] ram_addr;
    logic [DATA-1:0] ram_write;
    logic [DATA-1:0] ram_read;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rvalid,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rvalid,
        output rdata,
        output ram_we, ram_addr, ram_write,
        input  ram_read
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rvalid,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rvalid,
        input  rdata,
        input  ram_we, ram_addr, ram_write,
        output ram_read
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares BRAM port A between two requesters, round-robin with burst cap.
// Define BRAM_ARB_FIXED_PRIO_EN to make requester 0 always win.
module bram_port_arbiter #(
    parameter int DATA      = 8,
    parameter int ADDR      = 10,
    parameter int MAX_BURST = 4
) (
    input logic                clk,
    input logic                reset_n,
    bram_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    logic            owner_q, owner_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      rvalid_q, rvalid_d;
    logic [ADDR-1:0] addr_q, addr_d;

    logic [1:0]      req;
    logic            go;
    logic            sel;
    logic            sel_we;
    logic [ADDR-1:0] sel_addr;
    logic [DATA-1:0] sel_wdata;

    assign req = {bus.m1_req, bus.m0_req};

`ifdef BRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        go  = 1'b0;
        sel = 1'b0;
        if (req[0]) begin
            go  = 1'b1;
            sel = 1'b0;
        end else if (req[1]) begin
            go  = 1'b1;
            sel = 1'b1;
        end
        if (!reset_n) go = 1'b0;
    end
`else
    logic other;
    logic keep;

    assign other = ~owner_q;

    // Stay with the owner until its burst is used up, unless nobody else wants in.
    always_comb begin
        keep = busy_q & req[owner_q]
             & ((cnt_q < CNT_MAX) | ~req[other]);
        go   = 1'b0;
        sel  = owner_q;
        if (keep) begin
            go  = 1'b1;
            sel = owner_q;
        end else if (req[other]) begin
            go  = 1'b1;
            sel = other;
        end else if (req[owner_q]) begin
            go  = 1'b1;
            sel = owner_q;
        end
        if (!reset_n) go = 1'b0;
    end
`endif

    always_comb begin
        sel_we    = sel ? bus.m1_we    : bus.m0_we;
        sel_addr  = sel ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = sel ? bus.m1_wdata : bus.m0_wdata;
    end

    always_comb begin
        owner_d  = owner_q;
        busy_d   = 1'b0;
        cnt_d    = '0;
        rvalid_d = 2'b00;
        addr_d   = addr_q;
        if (go) begin
            owner_d       = sel;
            busy_d        = 1'b1;
            addr_d        = sel_addr;
            rvalid_d[sel] = ~sel_we;
`ifdef BRAM_ARB_FIXED_PRIO_EN
            cnt_d = '0;
`else
            if (busy_q && (sel == owner_q)) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = CW'(1);
            end
`endif
        end
    end

    assign bus.m0_ack    = go & ~sel;
    assign bus.m1_ack    = go & sel;
    assign bus.m0_rvalid = rvalid_q[0];
    assign bus.m1_rvalid = rvalid_q[1];
    assign bus.rdata     = bus.ram_read;
    assign bus.ram_we    = go & sel_we;
    // Idle cycles park the address on the last access instead of toggling.
    assign bus.ram_addr  = go ? sel_addr : addr_q;
    assign bus.ram_write = sel_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q  <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            rvalid_q <= 2'b00;
            addr_q   <= '0;
        end else begin
            owner_q  <= owner_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            addr_q   <= addr_d;
        end
    end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: op queues per requester, BRAM model,
// read-data scoreboard and per-scenario ack-order checks.
module tb_bram_port_arbiter;
    localparam int DATA = 8;
    localparam int ADDR = 10;
    localparam int MB   = 4;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct packed {
        logic            we;
        logic [ADDR-1:0] addr;
        logic [DATA-1:0] wdata;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_port_arbiter_if #(.DATA(DATA), .ADDR(ADDR)) bus ();

    bram_port_arbiter #(
        .DATA(DATA), .ADDR(ADDR), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .reset_n(rst_n), .bus(bus)
    );

    logic [DATA-1:0] mem [1024];
    logic [ADDR-1:0] ram_addr_r;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_write;
        end
        ram_addr_r <= bus.ram_addr;
    end
    assign bus.ram_read = mem[ram_addr_r];

    int tests = 0;
    int fails = 0;
    op_t q0[$];
    op_t q1[$];
    logic [DATA-1:0] e0[$];
    logic [DATA-1:0] e1[$];
    logic [1:0] alog[$];
    bit p0 = 0;
    bit p1 = 0;
    logic [DATA-1:0] last_rd0, last_rd1;
    logic [DATA-1:0] ref_mem [1024];

    function automatic op_t mk(logic we, logic [ADDR-1:0] a, logic [DATA-1:0] d);
        op_t o;
        o.we = we; o.addr = a; o.wdata = d;
        return o;
    endfunction

    function automatic int first_diff(input logic [1:0] got[$], input logic [1:0] exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            if (i >= got.size()) return i;
            if (got[i] !== exp[i]) return i;
        end
        for (int i = exp.size(); i < got.size(); i++) begin
            if (got[i] !== 2'b00) return i;
        end
        return -1;
    endfunction

    // Requester driver and read-data monitor: observe mid-cycle, drive after the edge.
    initial begin : drv
        logic a0, a1;
        op_t o;
        logic [DATA-1:0] x;
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tests++;
                if (bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0 || bus.ram_we !== 1'b0
                    || bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_outputs: ack=%b%b ram_we=%b rvalid=%b%b, required all 0",
                             bus.m1_ack, bus.m0_ack, bus.ram_we, bus.m1_rvalid, bus.m0_rvalid);
                end
                p0 = 0; p1 = 0;
                e0.delete(); e1.delete();
                for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 7 + 3);
            end else begin
                a0 = bus.m0_ack;
                a1 = bus.m1_ack;
                tests++;
                if (bus.m0_rvalid !== p0) begin
                    fails++;
                    $display("FAIL m0_rvalid: got %b required %b", bus.m0_rvalid, p0);
                end
                tests++;
                if (bus.m1_rvalid !== p1) begin
                    fails++;
                    $display("FAIL m1_rvalid: got %b required %b", bus.m1_rvalid, p1);
                end
                if (bus.m0_rvalid === 1'b1 && e0.size() > 0) begin
                    x = e0.pop_front();
                    last_rd0 = bus.rdata;
                    tests++;
                    if (bus.rdata !== x) begin
                        fails++;
                        $display("FAIL m0_rdata: got %h required %h", bus.rdata, x);
                    end
                end
                if (bus.m1_rvalid === 1'b1 && e1.size() > 0) begin
                    x = e1.pop_front();
                    last_rd1 = bus.rdata;
                    tests++;
                    if (bus.rdata !== x) begin
                        fails++;
                        $display("FAIL m1_rdata: got %h required %h", bus.rdata, x);
                    end
                end
                tests++;
                if ((a0 === 1'b1 && a1 === 1'b1) || (a0 === 1'b1 && q0.size() == 0)
                    || (a1 === 1'b1 && q1.size() == 0)) begin
                    fails++;
                    $display("FAIL ack_legal: ack=%b%b pending=%0d/%0d, required at most one ack of a pending op",
                             a1, a0, q1.size(), q0.size());
                end
                p0 = 0; p1 = 0;
                if (a0 === 1'b1 && q0.size() > 0) begin
                    o = q0.pop_front();
                    tests++;
                    if (bus.ram_addr !== o.addr || bus.ram_we !== o.we
                        || (o.we && bus.ram_write !== o.wdata)) begin
                        fails++;
                        $display("FAIL m0_ram_port: got we=%b addr=%h wr=%h required we=%b addr=%h wr=%h",
                                 bus.ram_we, bus.ram_addr, bus.ram_write, o.we, o.addr, o.wdata);
                    end
                    if (o.we) ref_mem[o.addr] = o.wdata;
                    else begin e0.push_back(ref_mem[o.addr]); p0 = 1; end
                end else if (a1 === 1'b1 && q1.size() > 0) begin
                    o = q1.pop_front();
                    tests++;
                    if (bus.ram_addr !== o.addr || bus.ram_we !== o.we
                        || (o.we && bus.ram_write !== o.wdata)) begin
                        fails++;
                        $display("FAIL m1_ram_port: got we=%b addr=%h wr=%h required we=%b addr=%h wr=%h",
                                 bus.ram_we, bus.ram_addr, bus.ram_write, o.we, o.addr, o.wdata);
                    end
                    if (o.we) ref_mem[o.addr] = o.wdata;
                    else begin e1.push_back(ref_mem[o.addr]); p1 = 1; end
                end else begin
                    tests++;
                    if (bus.ram_we !== 1'b0) begin
                        fails++;
                        $display("FAIL idle_we: got %b required 0", bus.ram_we);
                    end
                end
                alog.push_back({a1, a0});
            end
            @(posedge clk);
            #1;
            bus.m0_req = (q0.size() > 0);
            if (q0.size() > 0) begin
                bus.m0_we = q0[0].we; bus.m0_addr = q0[0].addr; bus.m0_wdata = q0[0].wdata;
            end
            bus.m1_req = (q1.size() > 0);
            if (q1.size() > 0) begin
                bus.m1_we = q1[0].we; bus.m1_addr = q1[0].addr; bus.m1_wdata = q1[0].wdata;
            end
        end
    end

    task automatic wait_idle(string nm);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || p0 || p1) && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        tests++;
        if (n >= 200) begin
            fails++;
            $display("FAIL %s_timeout: %0d cycles, required under 200", nm, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        q0.push_back(mk(1'b0, 10'h010, 8'h00));
        q1.push_back(mk(1'b0, 10'h020, 8'h00));
        @(posedge clk);
        #2;
        tests++;
        if (bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0 || bus.ram_we !== 1'b0) begin
            fails++;
            $display("FAIL reset_req_ack: ack=%b%b we=%b required 000",
                     bus.m1_ack, bus.m0_ack, bus.ram_we);
        end
    endtask

    task automatic test_tie();
        logic [1:0] exp[$];
        int d;
        alog.delete();
        rst_n = 1'b1;
        wait_idle("tie");
        exp = '{2'b01, 2'b10};
        d = first_diff(alog, exp);
        tests++;
        if (d !== -1) begin
            fails++;
            $display("FAIL tie_order: ack[%0d] got %b required %b", d,
                     d < alog.size() ? alog[d] : 2'bxx, d < exp.size() ? exp[d] : 2'b00);
        end
    endtask

    task automatic test_single();
        logic [1:0] exp[$];
        int d;
        @(posedge clk);
        alog.delete();
        q0.push_back(mk(1'b1, 10'h005, 8'hA5));
        q0.push_back(mk(1'b0, 10'h005, 8'h00));
        wait_idle("single");
        exp = '{2'b01, 2'b01};
        d = first_diff(alog, exp);
        tests++;
        if (d !== -1) begin
            fails++;
            $display("FAIL single_acks: ack[%0d] got %b required %b", d,
                     d < alog.size() ? alog[d] : 2'bxx, d < exp.size() ? exp[d] : 2'b00);
        end
        tests++;
        if (last_rd0 !== 8'hA5) begin
            fails++;
            $display("FAIL single_rdata: got %h required a5", last_rd0);
        end
    endtask

    task automatic test_burst();
        logic [1:0] exp[$];
        int d;
        int m1pos;
        @(posedge clk);
        alog.delete();
        for (int i = 0; i < 10; i++) q0.push_back(mk(1'b0, 10'(12'h100 + i), 8'h00));
        repeat (2) @(posedge clk);
        q1.push_back(mk(1'b0, 10'h200, 8'h00));
        wait_idle("burst");
        m1pos = FIXED ? 10 : MB;
        for (int i = 0; i < 11; i++) exp.push_back(i == m1pos ? 2'b10 : 2'b01);
        d = first_diff(alog, exp);
        tests++;
        if (d !== -1) begin
            fails++;
            $display("FAIL burst_order: ack[%0d] got %b required %b", d,
                     d < alog.size() ? alog[d] : 2'bxx, d < exp.size() ? exp[d] : 2'b00);
        end
    endtask

    task automatic test_cross();
        logic [1:0] exp[$];
        int d;
        @(posedge clk);
        alog.delete();
        q1.push_back(mk(1'b1, 10'h3FF, 8'h5A));
        @(posedge clk);
        q0.push_back(mk(1'b0, 10'h3FF, 8'h00));
        wait_idle("cross");
        exp = '{2'b10, 2'b01};
        d = first_diff(alog, exp);
        tests++;
        if (d !== -1) begin
            fails++;
            $display("FAIL cross_order: ack[%0d] got %b required %b", d,
                     d < alog.size() ? alog[d] : 2'bxx, d < exp.size() ? exp[d] : 2'b00);
        end
        tests++;
        if (last_rd0 !== 8'h5A) begin
            fails++;
            $display("FAIL cross_rdata: got %h required 5a", last_rd0);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp[$];
        int d;
        @(posedge clk);
        alog.delete();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1'b0, 10'(12'h100 + i), 8'h00));
            q1.push_back(mk(1'b0, 10'(12'h3FD + i), 8'h00));
        end
        wait_idle("b2b");
        for (int i = 0; i < 6; i++) begin
            if (FIXED) exp.push_back(i < 3 ? 2'b01 : 2'b10);
            else exp.push_back(i < 3 ? 2'b10 : 2'b01);
        end
        d = first_diff(alog, exp);
        tests++;
        if (d !== -1) begin
            fails++;
            $display("FAIL b2b_order: ack[%0d] got %b required %b", d,
                     d < alog.size() ? alog[d] : 2'bxx, d < exp.size() ? exp[d] : 2'b00);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp[$];
        int d;
        int n;
        @(posedge clk);
        alog.delete();
        q1.push_back(mk(1'b0, 10'h3FF, 8'h00));
        n = 0;
        while (alog.size() == 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $display("FAIL rstmid_ack_timeout: %0d cycles, required under 50", n);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.m1_rvalid !== 1'b0 || bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_outputs: rvalid1=%b ack=%b%b required 0 00",
                     bus.m1_rvalid, bus.m1_ack, bus.m0_ack);
        end
        q0.push_back(mk(1'b0, 10'h00A, 8'h00));
        q1.push_back(mk(1'b0, 10'h00B, 8'h00));
        repeat (2) @(posedge clk);
        alog.delete();
        #2;
        rst_n = 1'b1;
        wait_idle("rstmid");
        exp = '{2'b01, 2'b10};
        d = first_diff(alog, exp);
        tests++;
        if (d !== -1) begin
            fails++;
            $display("FAIL rstmid_tie: ack[%0d] got %b required %b", d,
                     d < alog.size() ? alog[d] : 2'bxx, d < exp.size() ? exp[d] : 2'b00);
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_burst();
        test_cross();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
Two-requester arbiter that shares the single read/write port A of a synchronous dual-port block RAM (registered-address, 1-cycle read latency). Each requester issues single-word reads or writes with a req/ack handshake and receives read data through a per-requester valid strobe. Round-robin with a bounded burst length, so one CPU-side master and one DMA-side master can share a RAM without starving each other. Port B of the RAM is not touched by this block.

Parameters:
DATA, 8, data word width (matches RAM DATA)
ADDR, 10, word address width (matches RAM ADDR)
MAX_BURST, 4, max consecutive accesses by one owner while the other requests; must be >= 1

Ports:
clk  in  1  single system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
m0_req  in  1  requester 0 access request; hold with m0_we/m0_addr/m0_wdata stable until m0_ack
m0_we  in  1  1 = write, 0 = read
m0_addr  in  ADDR  word address
m0_wdata  in  DATA  write data
m0_ack  out  1  combinational: access issued to RAM this cycle
m0_rvalid  out  1  registered: rdata holds m0 read result this cycle
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rvalid: same as m0 for requester 1
rdata  out  DATA  shared read data, = ram_read (combinational pass-through)
ram_we  out  1  to RAM a_we
ram_addr  out  ADDR  to RAM a_addr
ram_write  out  DATA  to RAM a_write
ram_read  in  DATA  from RAM a_read

Behaviour:
- Registered state: owner (1 bit, last served), busy (1 bit), cnt (clog2(MAX_BURST+1) bits, saturating), m0_rvalid, m1_rvalid.
- Reset values: owner=1 (requester 0 wins first tie), busy=0, cnt=0, m0_rvalid=m1_rvalid=0. Combinational outputs under reset: acks 0, ram_we 0.
- Selection each cycle (combinational), "other" = !owner:
  - keep: busy & req[owner] & (cnt < MAX_BURST | !req[other]) -> sel=owner
  - else if req[other] -> sel=other
  - else if req[owner] -> sel=owner (new burst, cnt restarts)
  - else no access.
- Issue: when sel valid, ack[sel]=1, ram_addr/ram_write/ram_we driven from sel's inputs; ram_we=req&we of sel only. No access: ram_we=0, ram_addr holds last issued address (registered mux select, no glitching toggles required).
- Update on issue: owner<=sel; busy<=1; cnt <= (busy & sel==owner) ? sat(cnt+1) : 1. No issue: busy<=0, cnt<=0, owner unchanged.
- Read latency: read issued in cycle N -> rvalid[sel]=1 in cycle N+1 with rdata = mem[addr]. Writes produce no rvalid. Back-to-back reads give rvalid every cycle.
- Switch between owners costs zero idle cycles.
- Read at address just written by the other requester in the previous cycle returns the new data (RAM write precedes registered-address read).
- Write and read to the same address in the same cycle cannot occur (one access per cycle).
- reset_n asserted mid-burst: pending rvalid discarded, state to reset values immediately.
- Requester deasserting req before ack: request withdrawn, no access.

Optional Feature:
BRAM_ARB_FIXED_PRIO_EN
- Defined: sel = m0 if m0_req else m1 if m1_req; requester 0 always wins, burst counter and round-robin unused (cnt held 0); m1 can starve.
- Undefined: round-robin with MAX_BURST limit as above.

Test Plan:
- Single write/read: m0 write addr 0x005 data 0xA5, then read 0x005 -> m0_ack both cycles, m0_rvalid 1 cycle after read ack with rdata 0xA5, m1_rvalid stays 0.
- Tie after reset: m0 and m1 both req read in same cycle -> m0_ack first, m1_ack next cycle; rvalids follow in order m0 then m1.
- Burst limit: m0 holds req for 10 reads, m1 requests from cycle 2, MAX_BURST=4 -> m0 gets 4 consecutive acks, then m1 ack, then m0 resumes.
- Cross visibility: m1 writes 0x3FF<-0x5A, m0 reads 0x3FF in the next cycle -> rdata 0x5A with m0_rvalid.
- Reset mid-burst: assert reset_n=0 one cycle after m1 read ack -> m1_rvalid 0, acks 0, after release first tie goes to m0.
- With BRAM_ARB_FIXED_PRIO_EN: m0 and m1 requesting continuously for 8 cycles -> 8 m0 acks, 0 m1 acks; m1 acked in the first cycle m0_req=0.
